// File: rtl/esn_step_scheduler.sv
// -----------------------------------------------------------------------------
// esn_step_scheduler
//
// Purpose
//   Drives one integer-ESN time step through a single shared interpreter
//   datapath. Neurons are processed one at a time: the committed reservoir
//   state is presented together with a neuron (weight-row) select, the
//   interpreter is kicked with a one-cycle enable, and its result is
//   saturated to the state element width and parked in a pending buffer.
//   When every neuron has a result, the whole pending buffer is copied into
//   the state vector in one cycle, so every neuron of a step sees the same
//   previous state (synchronous reservoir update).
//
// Ports
//   iClk        clock, rising edge
//   iRst        asynchronous active-high reset
//   iStart      request one time step (looked at only while idle)
//   iClear      zero the state vector (looked at only while idle, iStart wins)
//   oIntEn      one-cycle enable pulse to the interpreter
//   oIntData    committed state vector, element k at [k*data_width +: data_width]
//   oNeuronSel  index of the neuron being computed, 0 while idle
//   iIntValue   interpreter result, signed
//   iIntRdy     interpreter ready level
//   oState      same committed state vector as oIntData
//   oBusy       high whenever a step is in progress
//   oDone       one-cycle pulse once the step has been committed
//   oErr        sticky flag: some neuron timed out waiting for ready
//   oStepCount  number of completed steps, wraps at 16 bits
// -----------------------------------------------------------------------------
module esn_step_scheduler #(
    parameter int reservoir_size = 4,
    parameter int data_width     = 3,
    parameter int result_width   = 41,
    parameter int timeout_cycles = 255,
    parameter int idx_width      = 2
) (
    input  logic                                 iClk,
    input  logic                                 iRst,
    input  logic                                 iStart,
    input  logic                                 iClear,
    output logic                                 oIntEn,
    output logic [reservoir_size*data_width-1:0] oIntData,
    output logic [idx_width-1:0]                 oNeuronSel,
    input  logic [result_width-1:0]              iIntValue,
    input  logic                                 iIntRdy,
    output logic [reservoir_size*data_width-1:0] oState,
    output logic                                 oBusy,
    output logic                                 oDone,
    output logic                                 oErr,
    output logic [15:0]                          oStepCount
);

    localparam int vecWidth = reservoir_size * data_width;
    localparam int wdWidth  = $clog2(timeout_cycles + 1);

    // FSM encoding
    localparam logic [2:0] stIdle    = 3'd0;
    localparam logic [2:0] stDrain   = 3'd1;
    localparam logic [2:0] stIssue   = 3'd2;
    localparam logic [2:0] stWaitRdy = 3'd3;
    localparam logic [2:0] stWrite   = 3'd4;
    localparam logic [2:0] stCommit  = 3'd5;

    localparam logic [idx_width-1:0] lastIdx = idx_width'(reservoir_size - 1);
    localparam logic [wdWidth-1:0]   wdLimit = wdWidth'(timeout_cycles);

    // Saturation bounds expressed at the interpreter result width so the
    // comparison is done on the full signed value. ~max equals -(max+1).
    localparam logic signed [result_width-1:0] satMax =
        result_width'((1 << (data_width - 1)) - 1);
    localparam logic signed [result_width-1:0] satMin = ~satMax;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [2:0]            fsmReg,  fsmNext;
    logic [idx_width-1:0]  idxReg,  idxNext;
    logic [wdWidth-1:0]    wdReg,   wdNext;
    logic [vecWidth-1:0]   stateVecReg;
    logic [data_width-1:0] pendingReg [reservoir_size];
    logic [vecWidth-1:0]   pendingFlat;
    logic                  doneReg;
    logic                  errReg;
    logic [15:0]           stepCntReg;

    // Single-cycle strobes decoded by the next-state logic
    logic                  capture;
    logic                  abort;
    logic                  clearVec;
    logic                  commit;

    logic [wdWidth-1:0]    wdInc;
    logic [data_width-1:0] satValue;

    assign wdInc = wdReg + 1'b1;

    // -------------------------------------------------------------------------
    // Saturate the interpreter result into one state element
    // -------------------------------------------------------------------------
    always_comb begin
        satValue = iIntValue[data_width-1:0];
        if ($signed(iIntValue) > satMax) begin
            satValue = satMax[data_width-1:0];
        end else if ($signed(iIntValue) < satMin) begin
            satValue = satMin[data_width-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        fsmNext  = fsmReg;
        idxNext  = idxReg;
        wdNext   = wdReg;
        capture  = 1'b0;
        abort    = 1'b0;
        clearVec = 1'b0;
        commit   = 1'b0;

        case (fsmReg)
            stIdle: begin
                // Start takes priority over clear when both are requested.
                if (iStart) begin
                    idxNext = '0;
                    fsmNext = stDrain;
                end else if (iClear) begin
                    clearVec = 1'b1;
                end
            end

            stDrain: begin
                // A ready level left over from the previous neuron must fall
                // before the next enable, otherwise it would be taken as the
                // answer to the new request.
                if (!iIntRdy) begin
                    fsmNext = stIssue;
                end
            end

            stIssue: begin
                wdNext  = '0;
                fsmNext = stWaitRdy;
            end

            stWaitRdy: begin
                // Ready is checked first so an answer arriving on the last
                // allowed cycle is still accepted.
                if (iIntRdy) begin
                    capture = 1'b1;
                    fsmNext = stWrite;
                end else begin
                    wdNext = wdInc;
                    if (wdInc == wdLimit) begin
                        abort   = 1'b1;
                        fsmNext = stWrite;
                    end
                end
            end

            stWrite: begin
                if (idxReg == lastIdx) begin
                    fsmNext = stCommit;
                end else begin
                    idxNext = idxReg + 1'b1;
                    fsmNext = stDrain;
                end
            end

            stCommit: begin
                commit  = 1'b1;
                fsmNext = stIdle;
            end

            default: begin
                fsmNext = stIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            fsmReg     <= stIdle;
            idxReg     <= '0;
            wdReg      <= '0;
            doneReg    <= 1'b0;
            errReg     <= 1'b0;
            stepCntReg <= '0;
        end else begin
            fsmReg     <= fsmNext;
            idxReg     <= idxNext;
            wdReg      <= wdNext;
            doneReg    <= commit;
            errReg     <= errReg | abort;
            stepCntReg <= stepCntReg + {15'd0, commit};
        end
    end

    // -------------------------------------------------------------------------
    // Pending buffer: one register per neuron, written only when that neuron
    // is the current one. A timed-out neuron contributes zero.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < reservoir_size; gi++) begin : gPending
            always_ff @(posedge iClk or posedge iRst) begin
                if (iRst) begin
                    pendingReg[gi] <= '0;
                end else if (idxReg == idx_width'(gi)) begin
                    if (capture) begin
                        pendingReg[gi] <= satValue;
                    end else if (abort) begin
                        pendingReg[gi] <= '0;
                    end
                end
            end

            assign pendingFlat[gi*data_width +: data_width] = pendingReg[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Committed state vector. Written only on commit or an idle clear, so it
    // stays constant for every neuron evaluated within a step.
    // -------------------------------------------------------------------------
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateVecReg <= '0;
        end else if (commit) begin
            stateVecReg <= pendingFlat;
        end else if (clearVec) begin
            stateVecReg <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign oIntEn     = (fsmReg == stIssue);
    assign oNeuronSel = ((fsmReg == stDrain) || (fsmReg == stIssue) ||
                         (fsmReg == stWaitRdy) || (fsmReg == stWrite)) ? idxReg : '0;
    assign oBusy      = (fsmReg != stIdle);
    assign oIntData   = stateVecReg;
    assign oState     = stateVecReg;
    assign oDone      = doneReg;
    assign oErr       = errReg;
    assign oStepCount = stepCntReg;

endmodule

// File: tb/tb_esn_step_scheduler.sv
// -----------------------------------------------------------------------------
// tb_esn_step_scheduler
//
// Directed bench for esn_step_scheduler (4 neurons, 3-bit state, 41-bit
// results, 8-cycle timeout). A small interpreter model answers each enable
// one cycle later with a per-neuron value from a table and can optionally
// keep ready high for extra cycles or never answer at all.
// -----------------------------------------------------------------------------
module tb_esn_step_scheduler;

    localparam int RS  = 4;
    localparam int DW  = 3;
    localparam int RW  = 41;
    localparam int TO  = 8;
    localparam int IW  = 2;

    logic              iClk = 1'b0;
    logic              iRst;
    logic              iStart;
    logic              iClear;
    logic              oIntEn;
    logic [RS*DW-1:0]  oIntData;
    logic [IW-1:0]     oNeuronSel;
    logic [RW-1:0]     iIntValue;
    logic              iIntRdy;
    logic [RS*DW-1:0]  oState;
    logic              oBusy;
    logic              oDone;
    logic              oErr;
    logic [15:0]       oStepCount;

    esn_step_scheduler #(
        .reservoir_size (RS),
        .data_width     (DW),
        .result_width   (RW),
        .timeout_cycles (TO),
        .idx_width      (IW)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iStart     (iStart),
        .iClear     (iClear),
        .oIntEn     (oIntEn),
        .oIntData   (oIntData),
        .oNeuronSel (oNeuronSel),
        .iIntValue  (iIntValue),
        .iIntRdy    (iIntRdy),
        .oState     (oState),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oErr       (oErr),
        .oStepCount (oStepCount)
    );

    always #5 iClk = ~iClk;

    // ------------------------------------------------------------------ checks
    int passCount = 0;
    int totalCount = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        totalCount++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end else begin
            passCount++;
            $display("ok   %s: 0x%0h", name, got);
        end
    endtask

    // ------------------------------------------------------ interpreter model
    logic signed [RW-1:0] respVals [RS];
    int                   holdCycles = 0;
    bit                   noRespond  = 0;
    int                   enCount    = 0;
    int                   holdLeft   = 0;
    logic [IW-1:0]        selLog [RS];

    initial begin : interpModel
        logic          en;
        logic [IW-1:0] sel;
        iIntRdy   = 1'b0;
        iIntValue = '0;
        forever begin
            @(negedge iClk);
            en  = oIntEn;
            sel = oNeuronSel;
            @(posedge iClk);
            #1;
            if (en) begin
                if (enCount < RS) selLog[enCount] = sel;
                enCount++;
                if (!noRespond) begin
                    iIntValue = respVals[sel];
                    iIntRdy   = 1'b1;
                    holdLeft  = holdCycles;
                end
            end else if (holdLeft > 0) begin
                holdLeft--;
            end else begin
                iIntRdy = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------ vector table
    typedef struct {
        logic signed [RW-1:0] vals [RS];
        int                   hold;
        logic [RS*DW-1:0]     expState;
        int                   expLat;
    } vec_t;

    vec_t vecs [5];
    logic [15:0] expCount = 16'd0;

    task automatic setVec(input int i, input logic signed [RW-1:0] v0, input logic signed [RW-1:0] v1,
                          input logic signed [RW-1:0] v2, input logic signed [RW-1:0] v3,
                          input int hold, input logic [RS*DW-1:0] st, input int lat);
        vecs[i].vals[0]  = v0;
        vecs[i].vals[1]  = v1;
        vecs[i].vals[2]  = v2;
        vecs[i].vals[3]  = v3;
        vecs[i].hold     = hold;
        vecs[i].expState = st;
        vecs[i].expLat   = lat;
    endtask

    task automatic armModel(input int i, input bit silent);
        for (int k = 0; k < RS; k++) respVals[k] = vecs[i].vals[k];
        holdCycles = vecs[i].hold;
        noRespond  = silent;
        enCount    = 0;
        for (int k = 0; k < RS; k++) selLog[k] = '1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge iClk);
            #1;
        end
    endtask

    // Pulse iStart and count cycles from the sampling edge to oDone.
    // Returns -1 if oDone never shows within the budget.
    task automatic doStep(input int budget, output int lat);
        iStart = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge iClk);
            #1;
            if (oDone) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic runRow(input int i, input logic expErr);
        int lat;
        idle(3);
        armModel(i, 1'b0);
        doStep(200, lat);
        expCount = expCount + 16'd1;
        check($sformatf("row%0d latency", i), 64'(lat), 64'(vecs[i].expLat));
        check($sformatf("row%0d oState", i), 64'(oState), 64'(vecs[i].expState));
        check($sformatf("row%0d oIntData", i), 64'(oIntData), 64'(vecs[i].expState));
        check($sformatf("row%0d enables", i), 64'(enCount), 64'(RS));
        check($sformatf("row%0d sel order", i), 64'({selLog[3], selLog[2], selLog[1], selLog[0]}), 64'h E4);
        check($sformatf("row%0d stepCount", i), 64'(oStepCount), 64'(expCount));
        check($sformatf("row%0d oErr", i), 64'(oErr), 64'(expErr));
        check($sformatf("row%0d busy at done", i), 64'(oBusy), 64'd0);
        idle(1);
        check($sformatf("row%0d done one cycle", i), 64'(oDone), 64'd0);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " oState"}, 64'(oState), 64'd0);
        check({tag, " oIntData"}, 64'(oIntData), 64'd0);
        check({tag, " oIntEn"}, 64'(oIntEn), 64'd0);
        check({tag, " oNeuronSel"}, 64'(oNeuronSel), 64'd0);
        check({tag, " oBusy"}, 64'(oBusy), 64'd0);
        check({tag, " oDone"}, 64'(oDone), 64'd0);
        check({tag, " oErr"}, 64'(oErr), 64'd0);
        check({tag, " oStepCount"}, 64'(oStepCount), 64'd0);
    endtask

    // ------------------------------------------------------------- main flow
    initial begin : mainFlow
        int  lat;
        bit  sawBusy;
        bit  found;

        // Packed state: element3..element0, 3 bits each.
        setVec(0, 41'sd1,   41'sd2,    -41'sd1, 41'sd3,  0, 12'h7D1, 17); // 3,-1,2,1
        setVec(1, 41'sd100, -41'sd100, 41'sd4,  -41'sd5, 0, 12'h8E3, 17); // -4,3,-4,3
        setVec(2, -41'sd2,  41'sd1,    41'sd0,  -41'sd3, 3, 12'hA0E, 23); // -3,0,1,-2
        setVec(3, 41'sd3,   -41'sd4,   -41'sd3, 41'sd2,  0, 12'h563, 17); // 2,-3,-4,3
        setVec(4, 41'h0FF_FFFF_FFFF, 41'h100_0000_0000, 41'sd7, -41'sd8, 0, 12'h8E3, 17);

        iRst   = 1'b1;
        iStart = 1'b0;
        iClear = 1'b0;
        armModel(0, 1'b0);
        idle(3);
        checkAllZero("in reset");
        iRst = 1'b0;
        idle(1);
        checkAllZero("after reset");

        // Table-driven steps
        for (int i = 0; i < 5; i++) runRow(i, 1'b0);

        // iStart+iClear together in idle, then iStart pulses while busy
        idle(3);
        setVec(0, 41'sd1, 41'sd2, -41'sd1, 41'sd3, 0, 12'h7D1, 17);
        armModel(0, 1'b0);
        iStart = 1'b1;
        iClear = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        iClear = 1'b0;
        check("start+clear not cleared", 64'(oIntData), 64'h8E3);
        check("start+clear busy", 64'(oBusy), 64'd1);
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            iStart = (c >= 3 && c <= 9);
            @(posedge iClk);
            #1;
            if (c < 16 && !oDone) begin
                if (oIntData !== 12'h8E3) check("state stable mid-step", 64'(oIntData), 64'h8E3);
            end
            if (oDone) begin
                lat = c;
                break;
            end
        end
        iStart = 1'b0;
        expCount = expCount + 16'd1;
        check("busy-start latency", 64'(lat), 64'd17);
        check("busy-start oState", 64'(oState), 64'h7D1);
        sawBusy = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge iClk);
            #1;
            if (oBusy) sawBusy = 1;
        end
        check("no queued step", 64'(sawBusy), 64'd0);
        check("busy-start stepCount", 64'(oStepCount), 64'(expCount));

        // Clear alone in idle
        iClear = 1'b1;
        @(posedge iClk);
        #1;
        iClear = 1'b0;
        check("clear oState", 64'(oState), 64'd0);
        check("clear busy", 64'(oBusy), 64'd0);
        check("clear stepCount", 64'(oStepCount), 64'(expCount));

        // Give the state a nonzero value, then a step where nothing answers
        runRow(0, 1'b0);
        idle(3);
        armModel(0, 1'b1);
        doStep(200, lat);
        expCount = expCount + 16'd1;
        check("timeout latency", 64'(lat), 64'd45);
        check("timeout oState", 64'(oState), 64'd0);
        check("timeout oErr", 64'(oErr), 64'd1);
        check("timeout enables", 64'(enCount), 64'(RS));
        check("timeout stepCount", 64'(oStepCount), 64'(expCount));

        // Error flag is sticky across a good step
        runRow(1, 1'b1);

        // Reset during WAIT_RDY of neuron 2
        idle(3);
        armModel(0, 1'b1);
        iStart = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge iClk);
            #1;
            if (oIntEn && oNeuronSel == 2'd2) begin
                found = 1;
                break;
            end
        end
        check("reached neuron 2 issue", 64'(found), 64'd1);
        @(posedge iClk);
        #1;
        check("in wait of neuron 2", 64'(oNeuronSel), 64'd2);
        iRst = 1'b1;
        #1;
        checkAllZero("mid-step reset");
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        expCount = 16'd0;
        runRow(0, 1'b0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/esn_step_scheduler.md
Name: esn_step_scheduler

Overview:
- Sequences one integer-ESN time step across all reservoir neurons using a single shared interpreter datapath (multiply, normalise, activate).
- For each neuron in turn: presents the current reservoir state vector and a neuron select, pulses the interpreter enable, waits for its ready, then saturates and captures the result.
- All new neuron values are committed together at the end of the step (synchronous reservoir update), then a done pulse is raised.
- Sits between the top-level time-step control and the interpreter instance.

Parameters:
- reservoir_size, 4, number of neurons; also the number of elements in the state vector.
- data_width, 3, signed width of one state element.
- result_width, 41, width of the interpreter result, signed two's complement.
- timeout_cycles, 255, maximum cycles to wait for interpreter ready before a forced abort of that neuron.
- idx_width, 2, width of the neuron index; must satisfy 2^idx_width >= reservoir_size.

Ports:
- iClk, input, 1, clock; all logic on the rising edge.
- iRst, input, 1, asynchronous active-high reset.
- iStart, input, 1, request one time step; sampled only in IDLE.
- iClear, input, 1, zero the state vector; honoured only in IDLE.
- oIntEn, output, 1, one-cycle enable pulse to the interpreter.
- oIntData, output, reservoir_size*data_width, committed state vector; element k occupies bits [k*data_width +: data_width].
- oNeuronSel, output, idx_width, index of the neuron currently being computed (weight-row select).
- iIntValue, input, result_width, interpreter result.
- iIntRdy, input, 1, interpreter ready (level).
- oState, output, reservoir_size*data_width, same committed state vector as oIntData.
- oBusy, output, 1, high in every state except IDLE.
- oDone, output, 1, one-cycle pulse when the step commit completes.
- oErr, output, 1, sticky timeout flag.
- oStepCount, output, 16, count of completed steps.

Behaviour:
- Reset (asynchronous): FSM goes to IDLE. Every output resets to 0: state vector, pending buffer, oIntEn, oNeuronSel, oBusy, oDone, oErr, oStepCount, watchdog.
- Reset mid-step: the step is abandoned and nothing is committed.

FSM states: IDLE, DRAIN, ISSUE, WAIT_RDY, WRITE, COMMIT.
- IDLE:
  - iStart=1: index <= 0, go to DRAIN.
  - iClear=1 and iStart=0: state vector <= 0, stay in IDLE.
  - iClear and iStart both high: iStart wins and iClear is ignored.
- DRAIN: wait for iIntRdy=0, so a stale ready level is never accepted. Then go to ISSUE.
- ISSUE: oIntEn=1 for exactly this cycle; watchdog <= 0; go to WAIT_RDY.
- WAIT_RDY:
  - iIntRdy=1: capture the saturated iIntValue into pending[index]; go to WRITE.
  - Otherwise the watchdog increments. When it reaches timeout_cycles: pending[index] <= 0, oErr <= 1, go to WRITE.
  - If ready and timeout occur in the same cycle, ready wins.
- WRITE:
  - index = reservoir_size-1: go to COMMIT.
  - Otherwise index increments and the FSM goes to DRAIN.
- COMMIT: state vector <= pending; oDone=1 for one cycle; oStepCount increments (wraps 0xFFFF to 0); go to IDLE.

Other rules:
- oNeuronSel equals the index from DRAIN through WRITE; it is 0 in IDLE.
- oIntData is stable for the whole step, because only COMMIT writes the state vector.
- Saturation: treat iIntValue as signed.
  - Values above 2^(data_width-1)-1 clip to +max.
  - Values below -2^(data_width-1) clip to -min.
  - Otherwise take the low data_width bits.
  - Example for data_width=3: clip range is [-4, 3].
- oErr is cleared only by iRst.
- iStart outside IDLE is ignored; requests are not queued.
- Minimum step latency, counted from the iStart sample to oDone: reservoir_size*4 + 1 cycles (iIntRdy returning one cycle after oIntEn, low otherwise).

Test Plan:
- Reset, then iStart; the interpreter model answers 1, 2, -1, 3 one cycle after each oIntEn -> oIntEn pulses 4 times; oNeuronSel steps 0, 1, 2, 3; oState = {3, -1, 2, 1} packed as 0b011_111_010_001; oDone pulses at cycle 17; oStepCount=1.
- Results 100, -100, 4, -5 -> oState elements become 3, -4, 3, -4 (saturation).
- Model holds iIntRdy high for 3 cycles after each answer -> DRAIN stalls and no neuron is double-captured. oDone still arrives after exactly 4 captures.
- Model never asserts ready, with timeout_cycles=8 -> each neuron aborts after 8 wait cycles; oErr=1; oState = 0; oDone still pulses.
- Assert iRst during WAIT_RDY of neuron 2 after a prior completed step -> all outputs are 0 immediately; the earlier state vector is lost (reset to 0); the next iStart restarts at neuron 0.
- iStart pulsed while oBusy=1, and iClear together with iStart in IDLE -> no second step starts; the state is not cleared; oStepCount advances by exactly 1.
